// File: rtl/dense_seq_pkg.sv
// Shared types and sizing helpers for the sequential dense layer.
package dense_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    function automatic int acc_width(input int width, input int n_in);
        return 2 * width + $clog2(n_in + 1);
    endfunction

endpackage

// File: rtl/dense_mac_lane.sv
// One neuron: accumulator plus shift/saturate/ReLU output register.
module dense_mac_lane
    import dense_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NFRAC = 4,
    parameter int ACC_W = 22,
    parameter int RELU  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic                    acc_en,
    input  logic                    latch,
    input  logic signed [WIDTH-1:0] bias_i,
    input  logic signed [WIDTH-1:0] x_i,
    input  logic signed [WIDTH-1:0] w_i,
    output logic        [WIDTH-1:0] y_o
);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        (ACC_W'(1) <<< (WIDTH - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [2*WIDTH-1:0] prod;
    logic        [WIDTH-1:0]   y_q, y_d, res;

    always_comb begin
        prod = x_i * w_i;
        acc_d = acc_q;
        if (init) begin
            acc_d = {{(ACC_W-WIDTH){bias_i[WIDTH-1]}}, bias_i} <<< NFRAC;
        end else if (acc_en) begin
            acc_d = acc_q + {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
        end
    end

    // Floor shift back to WIDTH format, then clamp to the word range.
    always_comb begin
        shifted = acc_q >>> NFRAC;
        if (shifted > SAT_MAX) begin
            res = SAT_MAX[WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            res = SAT_MIN[WIDTH-1:0];
        end else begin
            res = shifted[WIDTH-1:0];
        end
        if (RELU != 0 && res[WIDTH-1]) begin
            res = '0;
        end
        y_d = latch ? res : y_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            y_q   <= '0;
        end else begin
            acc_q <= acc_d;
            y_q   <= y_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/dense_layer_seq.sv
// Sequential fully-connected layer: one input element per cycle, all neurons in parallel.
module dense_layer_seq
    import dense_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NFRAC = 4,
    parameter int N_IN  = 32,
    parameter int N_OUT = 32,
    parameter int RELU  = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   wload_valid,
    input  logic [$clog2(N_IN*N_OUT+N_OUT)-1:0]    wload_addr,
    input  logic [WIDTH-1:0]                       wload_data,
    output logic                                   wload_ready,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [N_IN*WIDTH-1:0]                  in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [N_OUT*WIDTH-1:0]                 out_data
);

    localparam int NW        = N_IN * N_OUT + N_OUT;
    localparam int AW        = $clog2(NW);
    localparam int BIAS_BASE = N_IN * N_OUT;
    localparam int ACC_W     = acc_width(WIDTH, N_IN);
    localparam int KW        = $clog2(N_IN + 1);
    localparam int IW        = (N_IN > 1) ? $clog2(N_IN) : 1;

    state_t                  state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic [IW-1:0]           kidx;
    logic signed [WIDTH-1:0] x_q [N_IN];
    logic signed [WIDTH-1:0] x_d [N_IN];
    logic [WIDTH-1:0]        mem_q [NW];
    logic [WIDTH-1:0]        mem_d [NW];
    logic                    we, init, acc_en, latch;

    assign kidx = k_q[IW-1:0];

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        x_d     = x_q;
        we      = 1'b0;
        init    = 1'b0;
        acc_en  = 1'b0;
        latch   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A pending write always wins over a new input vector.
                if (wload_valid) begin
                    we = (32'(wload_addr) < NW);
                end else if (in_valid) begin
                    for (int i = 0; i < N_IN; i++) begin
                        x_d[i] = in_data[i*WIDTH +: WIDTH];
                    end
                    init    = 1'b1;
                    k_d     = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (k_q == KW'(N_IN)) begin
                    latch   = 1'b1;
                    state_d = DONE;
                end else begin
                    acc_en = 1'b1;
                    k_d    = k_q + KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    k_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[wload_addr] = wload_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            x_q     <= '{default: '0};
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
        end
    end

    // Coefficients survive reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign wload_ready = (state_q == IDLE);
    assign in_ready    = (state_q == IDLE) && !wload_valid;
    assign out_valid   = (state_q == DONE);

    for (genvar j = 0; j < N_OUT; j++) begin : g_lane
        logic [AW-1:0] w_addr;
        assign w_addr = AW'(32'(kidx) * N_OUT + j);

        dense_mac_lane #(
            .WIDTH (WIDTH),
            .NFRAC (NFRAC),
            .ACC_W (ACC_W),
            .RELU  (RELU)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .init   (init),
            .acc_en (acc_en),
            .latch  (latch),
            .bias_i (mem_q[BIAS_BASE + j]),
            .x_i    (x_q[kidx]),
            .w_i    (mem_q[w_addr]),
            .y_o    (out_data[j*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Bench for dense_layer_seq: RELU=1 and RELU=0 instances in lockstep against an arithmetic model.
module tb_dense_layer_seq;

    localparam int W     = 8;
    localparam int NFRAC = 4;
    localparam int N_IN  = 32;
    localparam int N_OUT = 32;
    localparam int NWT   = N_IN * N_OUT;
    localparam int NW    = NWT + N_OUT;
    localparam int AW    = $clog2(NW);
    localparam int VB    = N_OUT * W;

    logic          clk = 1'b0;
    logic          reset;
    logic          wload_valid;
    logic [AW-1:0] wload_addr;
    logic [W-1:0]  wload_data;
    logic          in_valid;
    logic [N_IN*W-1:0] in_data;
    logic          out_ready;

    logic          wr1, ir1, ov1, wr0, ir0, ov0;
    logic [VB-1:0] od1, od0;

    logic [VB-1:0] exp1, exp0;
    int            mw [N_IN][N_OUT];
    int            mb [N_OUT];
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    dense_layer_seq #(.WIDTH(W), .NFRAC(NFRAC), .N_IN(N_IN), .N_OUT(N_OUT), .RELU(1)) dut1 (
        .clk(clk), .reset(reset),
        .wload_valid(wload_valid), .wload_addr(wload_addr),
        .wload_data(wload_data), .wload_ready(wr1),
        .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1)
    );

    dense_layer_seq #(.WIDTH(W), .NFRAC(NFRAC), .N_IN(N_IN), .N_OUT(N_OUT), .RELU(0)) dut0 (
        .clk(clk), .reset(reset),
        .wload_valid(wload_valid), .wload_addr(wload_addr),
        .wload_data(wload_data), .wload_ready(wr0),
        .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0)
    );

    task automatic chk(input string name, input logic [VB-1:0] act, input logic [VB-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    // Real-valued meaning: out = sat(floor((bias*16 + sum x*w) / 16)), then optional ReLU.
    function automatic logic [VB-1:0] model(input logic [N_IN*W-1:0] v, input bit relu);
        logic [VB-1:0] r;
        logic [W-1:0]  xb;
        longint        acc, y;
        r = '0;
        for (int j = 0; j < N_OUT; j++) begin
            acc = longint'(mb[j]) * 16;
            for (int i = 0; i < N_IN; i++) begin
                xb = v[i*W +: W];
                acc += longint'($signed(xb)) * longint'(mw[i][j]);
            end
            y = acc >>> NFRAC;
            if (y > 127) y = 127;
            if (y < -128) y = -128;
            if (relu && y < 0) y = 0;
            r[j*W +: W] = y[W-1:0];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (ov1) chk("out_relu1", od1, exp1);
            if (ov0) chk("out_relu0", od0, exp0);
        end
    end

    task automatic wr(input int a, input int d);
        wload_valid = 1'b1;
        wload_addr  = AW'(a);
        wload_data  = W'(d);
        @(posedge clk); #1;
        wload_valid = 1'b0;
        if (a < NWT) mw[a / N_OUT][a % N_OUT] = d;
        else if (a < NW) mb[a - NWT] = d;
    endtask

    task automatic load_all(input int kind);
        int d;
        for (int a = 0; a < NW; a++) begin
            case (kind)
                0: d = (a < NWT && (a / N_OUT) == (a % N_OUT)) ? 16 : 0;
                1: d = (a < NWT) ? 127 : 0;
                2: d = (a < NWT) ? 0 : -8;
                default: d = int'($urandom_range(0, 255)) - 128;
            endcase
            wr(a, d);
        end
    endtask

    function automatic logic [N_IN*W-1:0] rand_vec();
        logic [N_IN*W-1:0] v;
        for (int k = 0; k < N_IN; k++) v[k*W +: W] = W'($urandom_range(0, 255));
        return v;
    endfunction

    task automatic prep(input logic [N_IN*W-1:0] v);
        exp1 = model(v, 1'b1);
        exp0 = model(v, 1'b0);
    endtask

    task automatic accept(input logic [N_IN*W-1:0] v);
        in_data  = v;
        in_valid = 1'b1;
        #1;
        chk("in_ready_idle", VB'(ir1), VB'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic finish_vec(input int hold, input bit use_lit,
                              input logic [VB-1:0] lit1, input logic [VB-1:0] lit0);
        int cnt;
        logic [VB-1:0] snap;
        cnt = 0;
        while (!ov1 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("latency", VB'(cnt), VB'(N_IN + 1));
        if (use_lit) begin
            chk("lit_relu1", od1, lit1);
            chk("lit_relu0", od0, lit0);
        end
        snap = od1;
        for (int h = 0; h < hold; h++) begin
            wload_valid = 1'b1;
            wload_addr  = '0;
            wload_data  = 8'h55;
            in_valid    = 1'b1;
            #1;
            chk("bp_in_ready", VB'(ir1), VB'(0));
            chk("bp_wload_ready", VB'(wr1), VB'(0));
            @(posedge clk); #1;
            chk("bp_stable", od1, snap);
            chk("bp_valid", VB'(ov1), VB'(1));
        end
        wload_valid = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("drain_valid", VB'(ov1), VB'(0));
        chk("drain_idle", VB'(ir1), VB'(1));
    endtask

    task automatic run_vec(input logic [N_IN*W-1:0] v, input int hold, input bit use_lit,
                           input logic [VB-1:0] lit1, input logic [VB-1:0] lit0);
        prep(v);
        accept(v);
        finish_vec(hold, use_lit, lit1, lit0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        logic [N_IN*W-1:0] v;
        logic [VB-1:0] l_18, l_7f, l_80, l_f8, zero;
        v = '0; l_18 = '0; l_7f = '0; l_80 = '0; l_f8 = '0; zero = '0;
        for (int j = 0; j < N_OUT; j++) begin
            l_18[j*W +: W] = 8'h18;
            l_7f[j*W +: W] = 8'h7F;
            l_80[j*W +: W] = 8'h80;
            l_f8[j*W +: W] = 8'hF8;
        end
        exp1 = '0; exp0 = '0;
        reset = 1'b1;
        wload_valid = 1'b0; wload_addr = '0; wload_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_out_valid", VB'(ov1), VB'(0));
        chk("rst_in_ready", VB'(ir1), VB'(1));
        chk("rst_wload_ready", VB'(wr1), VB'(1));
        chk("rst_out_data", od1, zero);
        chk("rst_out_data0", od0, zero);

        load_all(0);
        run_vec(l_18, 0, 1'b1, l_18, l_18);
        run_vec(rand_vec(), 0, 1'b0, zero, zero);

        load_all(1);
        run_vec(l_7f, 10, 1'b1, l_7f, l_7f);
        run_vec(l_80, 0, 1'b1, zero, l_80);

        load_all(2);
        run_vec(rand_vec(), 0, 1'b1, zero, l_f8);

        load_all(3);
        wr(NW, 8'h33);
        wr((1 << AW) - 1, 8'h22);
        run_vec(rand_vec(), 0, 1'b0, zero, zero);

        v = rand_vec();
        prep(v);
        accept(v);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", VB'(ov1), VB'(0));
        chk("midrst_in_ready", VB'(ir1), VB'(1));
        chk("midrst_out_data", od1, zero);
        run_vec(v, 0, 1'b0, zero, zero);

        v = rand_vec();
        wload_valid = 1'b1;
        wload_addr  = AW'(NWT + 3);
        wload_data  = 8'h40;
        in_valid    = 1'b1;
        in_data     = v;
        #1;
        chk("coll_in_ready", VB'(ir1), VB'(0));
        chk("coll_wload_ready", VB'(wr1), VB'(1));
        @(posedge clk); #1;
        wload_valid = 1'b0;
        mb[3] = 64;
        prep(v);
        #1;
        chk("coll_in_ready_next", VB'(ir1), VB'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        finish_vec(0, 1'b0, zero, zero);

        run_vec(rand_vec(), 0, 1'b0, zero, zero);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
